// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage has priority, the external
// X port is forced in for one stalled slot after bounded starvation.
module dm_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DEPTH      = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_p_req,
    input  logic          i_p_we,
    input  logic [AW-1:0] i_p_addr,
    input  logic [DW-1:0] i_p_wdata,
    output logic [DW-1:0] o_p_rdata,
    output logic          o_p_stall,
    input  logic          i_x_req,
    input  logic          i_x_we,
    input  logic [AW-1:0] i_x_addr,
    input  logic [DW-1:0] i_x_wdata,
    output logic          o_x_ack,
    output logic          o_x_err,
    output logic [DW-1:0] o_x_rdata,
    output logic          o_dm_we,
    output logic [AW-1:0] o_dm_a,
    output logic [DW-1:0] o_dm_wd,
    input  logic [DW-1:0] i_dm_rd
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

    typedef enum logic {XIDLE, XACK} xstate_t;

    xstate_t       r_state;
    logic [CW-1:0] r_starve;
    logic          r_x_err;
    logic [DW-1:0] r_x_rdata;

    logic w_x_inrange;
    logic w_starved;
    logic w_grant_x;

    assign w_x_inrange = (i_x_addr < AW'(DEPTH));
    // Counter saturates at C_MAX, so equality is the starvation test.
    assign w_starved   = (r_starve == C_MAX);
    assign w_grant_x   = i_x_req && (r_state == XIDLE)
                         && (!i_p_req || w_starved);

    assign o_p_stall = i_rst_n && w_grant_x && i_p_req;
    assign o_p_rdata = i_dm_rd;
    assign o_x_ack   = (r_state == XACK);
    assign o_x_err   = r_x_err;
    assign o_x_rdata = r_x_rdata;

    always_comb begin
        o_dm_a  = i_p_addr;
        o_dm_wd = i_p_wdata;
        o_dm_we = i_p_req && i_p_we;
        if (w_grant_x) begin
            o_dm_a  = i_x_addr;
            o_dm_wd = i_x_wdata;
            o_dm_we = i_x_we && w_x_inrange;
        end
        if (!i_rst_n) begin
            o_dm_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= XIDLE;
            r_starve  <= '0;
            r_x_err   <= 1'b0;
            r_x_rdata <= '0;
        end else begin
            unique case (r_state)
                XIDLE: begin
                    if (w_grant_x) begin
                        r_state   <= XACK;
                        r_x_err   <= !w_x_inrange;
                        r_x_rdata <= w_x_inrange ? i_dm_rd : '0;
                        r_starve  <= '0;
                    end else if (!i_x_req) begin
                        r_starve <= '0;
                    end else if (i_p_req && !w_starved) begin
                        r_starve <= r_starve + CW'(1);
                    end
                end
                XACK: begin
                    r_state <= XIDLE;
                    r_x_err <= 1'b0;
                    if (!i_x_req) begin
                        r_starve <= '0;
                    end
                end
                default: r_state <= XIDLE;
            endcase
        end
    end

endmodule
